edge_holdoff_multi: RTL and testbench

//  Multi-channel edge detector with per-channel hold-off (debounce) window, successor to the single-channel ms rising-edge block.

---
 rtl/edge_holdoff_pkg.sv | 40 ++++
 rtl/edge_holdoff_ch.sv | 150 +++++++++++++++
 rtl/edge_holdoff_multi.sv | 59 +++++
 tb/tb_edge_holdoff_multi.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_holdoff_pkg.sv
// ============================================================================
// edge_holdoff_pkg
// Shared definitions for the multi-channel edge detector with hold-off window.
//   MODE_OFF/RISE/FALL/BOTH : per-channel edge selection encodings
//   state_t                 : per-channel FSM states (ST_IDLE, ST_HOLD)
//   EVT_CNT_W               : width of each channel's accepted-edge counter
//   edgeQualifies()         : folds rise/fall detection with the channel mode
// ============================================================================
package edge_holdoff_pkg;

    localparam int EVT_CNT_W = 16;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // A detected transition only counts as an event if the channel's mode
    // asks for that direction; MODE_OFF masks everything.
    function automatic logic edgeQualifies(input logic [1:0] modeSel,
                                           input logic       rise,
                                           input logic       fall);
        logic result;
        result = 1'b0;
        case (modeSel)
            MODE_OFF:  result = 1'b0;
            MODE_RISE: result = rise;
            MODE_FALL: result = fall;
            MODE_BOTH: result = rise | fall;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/edge_holdoff_ch.sv
// ============================================================================
// edge_holdoff_ch
// One channel of the edge detector: synchronises an async input, detects the
// mode-selected edge, emits a 1-cycle pulse and then ignores the channel for
// HOLDOFF_CYC cycles. Edges arriving during the window set a sticky flag.
// Optional feature macro: EDGE_HOLDOFF_EVT_CNT_EN (saturating event counter).
// Ports:
//   clk_50M     in   system clock
//   arst        in   synchronous active-high reset
//   raw_sig     in   asynchronous input
//   mode        in   00 off, 01 rising, 10 falling, 11 both
//   clr_missed  in   1-cycle clear of the missed flag
//   clr_count   in   1-cycle clear of the event counter
//   edge_pulse  out  1-cycle pulse per accepted edge
//   busy        out  high while in hold-off
//   missed      out  sticky: qualifying edge seen during hold-off
//   evt_count   out  accepted-edge count (0 when counter feature disabled)
// ============================================================================
module edge_holdoff_ch
    import edge_holdoff_pkg::*;
#(
    parameter int HOLDOFF_CYC = 100000,
    parameter int CNT_W       = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50M,
    input  logic                 arst,
    input  logic                 raw_sig,
    input  logic [1:0]           mode,
    input  logic                 clr_missed,
    input  logic                 clr_count,
    output logic                 edge_pulse,
    output logic                 busy,
    output logic                 missed,
    output logic [EVT_CNT_W-1:0] evt_count
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       holdCnt_q, holdCnt_d;
    logic                   pulse_q, pulse_d;
    logic                   missed_q, missed_d;
    logic                   sampled;
    logic                   rise;
    logic                   fall;
    logic                   qualEdge;

    // Edge detection works on the last synchroniser stage against its own
    // delayed copy. prev resets to 0, so an input already high when reset
    // releases is seen as one rising edge.
    assign sampled  = sync_q[SYNC_STAGES-1];
    assign rise     = sampled & ~prev_q;
    assign fall     = ~sampled & prev_q;
    assign qualEdge = edgeQualifies(mode, rise, fall);

    // Synchroniser chain and previous-sample register. These run in every
    // state so detection is ready the first cycle the FSM returns to idle.
    always_ff @(posedge clk_50M) begin
        if (arst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_sig};
            prev_q <= sampled;
        end
    end

    // FSM state, hold-off counter, pulse and sticky missed flag registers.
    always_ff @(posedge clk_50M) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            holdCnt_q <= '0;
            pulse_q   <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            holdCnt_q <= holdCnt_d;
            pulse_q   <= pulse_d;
            missed_q  <= missed_d;
        end
    end

    // Next-state logic. An edge in idle is accepted immediately; during hold
    // the counter runs for exactly HOLDOFF_CYC cycles regardless of mode, and
    // any qualifying edge seen there (including the final cycle) is dropped
    // but recorded. The set is applied after the clear so it wins a tie.
    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        pulse_d   = 1'b0;
        missed_d  = missed_q;
        if (clr_missed) begin
            missed_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (qualEdge) begin
                    state_d   = ST_HOLD;
                    holdCnt_d = '0;
                    pulse_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (qualEdge) begin
                    missed_d = 1'b1;
                end
                if (holdCnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
                    holdCnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    holdCnt_d = holdCnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                holdCnt_d = '0;
            end
        endcase
    end

    assign edge_pulse = pulse_q;
    assign busy       = (state_q == ST_HOLD);
    assign missed     = missed_q;

`ifdef EDGE_HOLDOFF_EVT_CNT_EN
    logic [EVT_CNT_W-1:0] evtCnt_q;

    // Accepted-edge counter, updated alongside the pulse register. A clear
    // coinciding with an accepted edge leaves a count of one; otherwise the
    // count saturates at all-ones rather than wrapping.
    always_ff @(posedge clk_50M) begin
        if (arst) begin
            evtCnt_q <= '0;
        end else if (clr_count) begin
            evtCnt_q <= pulse_d ? EVT_CNT_W'(1) : '0;
        end else if (pulse_d && (evtCnt_q != {EVT_CNT_W{1'b1}})) begin
            evtCnt_q <= evtCnt_q + EVT_CNT_W'(1);
        end
    end

    assign evt_count = evtCnt_q;
`else
    logic unused_clr_count;

    assign unused_clr_count = clr_count;
    assign evt_count        = '0;
`endif

endmodule

// File: rtl/edge_holdoff_multi.sv
// ============================================================================
// edge_holdoff_multi
// Multi-channel edge detector with per-channel hold-off window. Instantiates
// N_CH independent edge_holdoff_ch channels and slices the buses.
// Optional feature macro: EDGE_HOLDOFF_EVT_CNT_EN (per-channel event counter).
// Ports:
//   clk_50M     in   system clock (50 MHz)
//   arst        in   synchronous active-high reset
//   raw_sig     in   [N_CH]       asynchronous inputs
//   mode        in   [2*N_CH]     per channel [2i+1:2i] edge select
//   clr_missed  in   [N_CH]       per-channel clear of missed flag
//   clr_count   in   [N_CH]       per-channel clear of event counter
//   edge_pulse  out  [N_CH]       1-cycle pulse per accepted edge
//   busy        out  [N_CH]       high during hold-off
//   missed      out  [N_CH]       sticky missed-edge flags
//   evt_count   out  [16*N_CH]    per-channel counts [16i+15:16i]
// ============================================================================
module edge_holdoff_multi
    import edge_holdoff_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int HOLDOFF_CYC = 100000,
    parameter int CNT_W       = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk_50M,
    input  logic                      arst,
    input  logic [N_CH-1:0]           raw_sig,
    input  logic [2*N_CH-1:0]         mode,
    input  logic [N_CH-1:0]           clr_missed,
    input  logic [N_CH-1:0]           clr_count,
    output logic [N_CH-1:0]           edge_pulse,
    output logic [N_CH-1:0]           busy,
    output logic [N_CH-1:0]           missed,
    output logic [EVT_CNT_W*N_CH-1:0] evt_count
);

    // Channels share nothing but clock and reset; there is deliberately no
    // arbitration between them.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_holdoff_ch #(
            .HOLDOFF_CYC (HOLDOFF_CYC),
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk_50M    (clk_50M),
            .arst       (arst),
            .raw_sig    (raw_sig[i]),
            .mode       (mode[2*i +: 2]),
            .clr_missed (clr_missed[i]),
            .clr_count  (clr_count[i]),
            .edge_pulse (edge_pulse[i]),
            .busy       (busy[i]),
            .missed     (missed[i]),
            .evt_count  (evt_count[EVT_CNT_W*i +: EVT_CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_holdoff_multi.sv
// ============================================================================
// tb_edge_holdoff_multi
// Directed bench for edge_holdoff_multi with HOLDOFF_CYC=8, SYNC_STAGES=2,
// N_CH=4. Counter expectations follow EDGE_HOLDOFF_EVT_CNT_EN.
// ============================================================================
module tb_edge_holdoff_multi;

    localparam int N_CH        = 4;
    localparam int HOLDOFF_CYC = 8;
    localparam int CNT_W       = 4;
    localparam int SYNC_STAGES = 2;

`ifdef EDGE_HOLDOFF_EVT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 clk_50M;
    logic                 arst;
    logic [N_CH-1:0]      raw_sig;
    logic [2*N_CH-1:0]    mode;
    logic [N_CH-1:0]      clr_missed;
    logic [N_CH-1:0]      clr_count;
    logic [N_CH-1:0]      edge_pulse;
    logic [N_CH-1:0]      busy;
    logic [N_CH-1:0]      missed;
    logic [16*N_CH-1:0]   evt_count;

    int compared;
    int mismatched;
    logic [N_CH-1:0] rawV;

    edge_holdoff_multi #(
        .N_CH        (N_CH),
        .HOLDOFF_CYC (HOLDOFF_CYC),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .clk_50M    (clk_50M),
        .arst       (arst),
        .raw_sig    (raw_sig),
        .mode       (mode),
        .clr_missed (clr_missed),
        .clr_count  (clr_count),
        .edge_pulse (edge_pulse),
        .busy       (busy),
        .missed     (missed),
        .evt_count  (evt_count)
    );

    // 50 MHz-style clock, posedges at 5, 15, 25 ...
    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    // Drive raw inputs, then advance the given number of rising edges and
    // settle 1 time unit past the last one so outputs are stable to sample.
    task automatic applyStimulus(input logic [N_CH-1:0] rawVal, input int cycles);
        raw_sig = rawVal;
        repeat (cycles) @(posedge clk_50M);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] cntOf(input int ch);
        return evt_count[16*ch +: 16];
    endfunction

    // Safety net in case something stalls the directed sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        arst       = 1'b1;
        rawV       = '0;
        raw_sig    = '0;
        clr_missed = '0;
        clr_count  = '0;
        mode       = 8'b00_10_11_01;

        // Reset state
        applyStimulus(rawV, 2);
        checkOutput("reset_pulse", 64'(edge_pulse), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        checkOutput("reset_missed", 64'(missed), 64'h0);
        checkOutput("reset_count", evt_count, 64'h0);
        arst = 1'b0;
        applyStimulus(rawV, 2);

        // 1: ch0 rising edge, latency and 8-cycle busy window
        $display("[TB] step 1: ch0 rising edge");
        rawV[0] = 1'b1;
        applyStimulus(rawV, 2);
        checkOutput("t1_pulse_early", 64'(edge_pulse[0]), 64'h0);
        applyStimulus(rawV, 1);
        checkOutput("t1_pulse", 64'(edge_pulse), 64'h1);
        checkOutput("t1_busy_first", 64'(busy[0]), 64'h1);
        checkOutput("t1_count", 64'(cntOf(0)), CNT_EN ? 64'h1 : 64'h0);
        applyStimulus(rawV, 1);
        checkOutput("t1_pulse_gone", 64'(edge_pulse[0]), 64'h0);
        checkOutput("t1_busy_2nd", 64'(busy[0]), 64'h1);
        applyStimulus(rawV, 6);
        checkOutput("t1_busy_last", 64'(busy[0]), 64'h1);
        applyStimulus(rawV, 1);
        checkOutput("t1_busy_end", 64'(busy[0]), 64'h0);
        checkOutput("t1_missed", 64'(missed[0]), 64'h0);

        // 2: ch1 both edges, fall lands in hold-off
        $display("[TB] step 2: ch1 short pulse");
        rawV[1] = 1'b1;
        applyStimulus(rawV, 3);
        checkOutput("t2_pulse", 64'(edge_pulse), 64'h2);
        checkOutput("t2_count", 64'(cntOf(1)), CNT_EN ? 64'h1 : 64'h0);
        rawV[1] = 1'b0;
        applyStimulus(rawV, 3);
        checkOutput("t2_no_2nd_pulse", 64'(edge_pulse[1]), 64'h0);
        checkOutput("t2_missed_set", 64'(missed[1]), 64'h1);
        checkOutput("t2_busy", 64'(busy[1]), 64'h1);
        clr_missed[1] = 1'b1;
        applyStimulus(rawV, 1);
        clr_missed[1] = 1'b0;
        checkOutput("t2_missed_clr", 64'(missed[1]), 64'h0);
        applyStimulus(rawV, 10);
        checkOutput("t2_count_after", 64'(cntOf(1)), CNT_EN ? 64'h1 : 64'h0);

        // 3: ch2 falling, second fall in first idle cycle is accepted
        $display("[TB] step 3: ch2 falling edges");
        rawV[2] = 1'b1;
        applyStimulus(rawV, 4);
        checkOutput("t3_rise_ignored", 64'(edge_pulse[2]), 64'h0);
        rawV[2] = 1'b0;
        applyStimulus(rawV, 3);
        checkOutput("t3_pulse1", 64'(edge_pulse[2]), 64'h1);
        rawV[2] = 1'b1;
        applyStimulus(rawV, 6);
        rawV[2] = 1'b0;
        applyStimulus(rawV, 2);
        checkOutput("t3_idle_pulse", 64'(edge_pulse[2]), 64'h0);
        checkOutput("t3_idle_busy", 64'(busy[2]), 64'h0);
        applyStimulus(rawV, 1);
        checkOutput("t3_pulse2", 64'(edge_pulse[2]), 64'h1);
        checkOutput("t3_busy2", 64'(busy[2]), 64'h1);
        checkOutput("t3_count", 64'(cntOf(2)), CNT_EN ? 64'h2 : 64'h0);
        checkOutput("t3_missed", 64'(missed[2]), 64'h0);
        applyStimulus(rawV, 10);

        // 4: ch3 mode off, toggles never produce anything on any channel
        $display("[TB] step 4: ch3 mode off toggles");
        for (int k = 0; k < 10; k++) begin
            rawV[3] = ~rawV[3];
            applyStimulus(rawV, 1);
            checkOutput("t4_pulse_all", 64'(edge_pulse), 64'h0);
            checkOutput("t4_busy_all", 64'(busy), 64'h0);
        end
        applyStimulus(rawV, 3);
        checkOutput("t4_pulse_tail", 64'(edge_pulse), 64'h0);
        checkOutput("t4_count3", 64'(cntOf(3)), 64'h0);
        checkOutput("t4_missed3", 64'(missed[3]), 64'h0);

        // 5: reset mid-hold on ch0, raw held high through release
        $display("[TB] step 5: reset during hold");
        rawV[0] = 1'b0;
        applyStimulus(rawV, 4);
        rawV[0] = 1'b1;
        applyStimulus(rawV, 3);
        checkOutput("t5_pulse", 64'(edge_pulse[0]), 64'h1);
        checkOutput("t5_count", 64'(cntOf(0)), CNT_EN ? 64'h2 : 64'h0);
        rawV[0] = 1'b0;
        applyStimulus(rawV, 2);
        rawV[0] = 1'b1;
        applyStimulus(rawV, 3);
        checkOutput("t5_missed_set", 64'(missed[0]), 64'h1);
        checkOutput("t5_busy_pre", 64'(busy[0]), 64'h1);
        arst = 1'b1;
        applyStimulus(rawV, 1);
        checkOutput("t5_rst_busy", 64'(busy), 64'h0);
        checkOutput("t5_rst_missed", 64'(missed), 64'h0);
        checkOutput("t5_rst_pulse", 64'(edge_pulse), 64'h0);
        checkOutput("t5_rst_count", evt_count, 64'h0);
        arst = 1'b0;
        applyStimulus(rawV, 2);
        checkOutput("t5_post_early", 64'(edge_pulse[0]), 64'h0);
        applyStimulus(rawV, 1);
        checkOutput("t5_post_pulse", 64'(edge_pulse), 64'h1);
        checkOutput("t5_post_count", 64'(cntOf(0)), CNT_EN ? 64'h1 : 64'h0);
        applyStimulus(rawV, 10);

`ifdef EDGE_HOLDOFF_EVT_CNT_EN
        // 6: saturation and clear-with-edge on ch0
        $display("[TB] step 6: counter saturation");
        force u_dut.g_ch[0].u_ch.evtCnt_q = 16'hFFFE;
        #1;
        release u_dut.g_ch[0].u_ch.evtCnt_q;
        rawV[0] = 1'b0;
        applyStimulus(rawV, 4);
        rawV[0] = 1'b1;
        applyStimulus(rawV, 3);
        checkOutput("t6_reach_max", 64'(cntOf(0)), 64'hFFFF);
        applyStimulus(rawV, 10);
        rawV[0] = 1'b0;
        applyStimulus(rawV, 4);
        rawV[0] = 1'b1;
        applyStimulus(rawV, 3);
        checkOutput("t6_sat_pulse", 64'(edge_pulse[0]), 64'h1);
        checkOutput("t6_saturated", 64'(cntOf(0)), 64'hFFFF);
        applyStimulus(rawV, 10);
        rawV[0] = 1'b0;
        applyStimulus(rawV, 4);
        rawV[0] = 1'b1;
        applyStimulus(rawV, 2);
        clr_count[0] = 1'b1;
        applyStimulus(rawV, 1);
        clr_count[0] = 1'b0;
        checkOutput("t6_clr_edge_pulse", 64'(edge_pulse[0]), 64'h1);
        checkOutput("t6_clr_edge_count", 64'(cntOf(0)), 64'h1);
        applyStimulus(rawV, 10);
        clr_count[0] = 1'b1;
        applyStimulus(rawV, 1);
        clr_count[0] = 1'b0;
        checkOutput("t6_clr_only", 64'(cntOf(0)), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
